instr_fetch: RTL

Multicycle instruction-fetch sequencer between the program counter and instruction memory. On a fetch request from the control unit it captures the current PC, performs one word read over a ready-handshake memory port, and latches the returned word into the instruction register. It then pulses `PC_inc` so the PC advances by 4. It also detects misaligned PCs and memory timeouts, and it supports a flush for redirects.

---
 rtl/mips_pkg.sv | 12 +
 rtl/instr_fetch_if.sv | 11 +
 rtl/instr_fetch_timer.sv | 19 +
 rtl/instr_fetch.sv | 58 +++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, reset values and the fetch FSM state encoding
package mips_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] IR_RESET = 32'h0;
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_READ = 2'd1,
    FS_DONE = 2'd2,
    FS_ERR  = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory read port (master = fetch unit, slave = memory)
//   mem_rd/mem_addr from master, mem_rdy/mem_dout from slave
interface instr_fetch_if;
  import mips_pkg::*;
  logic mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_rdy;
  logic [INSTR_W-1:0] mem_dout;
  modport master (output mem_rd, output mem_addr, input mem_rdy, input mem_dout);
  modport slave (input mem_rd, input mem_addr, output mem_rdy, output mem_dout);
endinterface

// File: rtl/instr_fetch_timer.sv
// fetch_timer: saturating READ wait counter; clr_i zeroes it, en_i counts,
//   expired_o flags that TIMEOUT-1 wait cycles have elapsed
module fetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired_o = cnt_q == W'(TIMEOUT - 1);
  always_comb cnt_d = clr_i ? '0 : (en_i && !expired_o) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: multicycle fetch sequencer PC -> instruction memory -> IR
//   in : clk, reset (async), PC_out, fetch_req, flush
//   out: IR_out, PC_inc, fetch_done, fetch_err, busy
//   mem: instr_fetch_if.master (mem_rd, mem_addr, mem_rdy, mem_dout)
import mips_pkg::*;
module instr_fetch #(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  PC_out,
  input  logic               fetch_req,
  input  logic               flush,
  output logic [INSTR_W-1:0] IR_out,
  output logic               PC_inc,
  output logic               fetch_done,
  output logic               fetch_err,
  output logic               busy,
  instr_fetch_if.master      mem
);
  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [INSTR_W-1:0] ir_q;
  logic start, load, expired;
  assign start = state_q == FS_IDLE && fetch_req && !flush && PC_out[1:0] == 2'b00;
  assign load = state_q == FS_READ && mem.mem_rdy && !flush;
  // flush wins over everything, including a same-cycle mem_rdy or timeout
  always_comb
    state_d = flush ? FS_IDLE :
              state_q == FS_IDLE ? (!fetch_req ? FS_IDLE : PC_out[1:0] != 2'b00 ? FS_ERR : FS_READ) :
              state_q == FS_READ ? (mem.mem_rdy ? FS_DONE : expired ? FS_ERR : FS_READ) :
              FS_IDLE;
  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (start),
    .en_i      (state_q == FS_READ && !mem.mem_rdy),
    .expired_o (expired)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= FS_IDLE;
      addr_q <= '0;
      ir_q <= IR_RESET;
    end else begin
      state_q <= state_d;
      if (start) addr_q <= PC_out;
      if (load) ir_q <= mem.mem_dout;
    end
  // all outputs decode registered state only
  assign mem.mem_rd = state_q == FS_READ;
  assign mem.mem_addr = addr_q;
  assign IR_out = ir_q;
  assign PC_inc = state_q == FS_DONE;
  assign fetch_done = state_q == FS_DONE;
  assign fetch_err = state_q == FS_ERR;
  assign busy = state_q != FS_IDLE;
endmodule
